aes_key_ctrl: RTL and testbench
===============================

Name: aes_key_ctrl

Overview:
Sequencer for the AES-128 key-schedule datapath (key_sch). Accepts a master key over a valid/ready handshake, steps the key schedule through round_nr 0..10 on consecutive cycles, and captures each round key into an 11-entry store. Once expansion is done, it serves round keys by index to the cipher round core over a request/valid read port. It sits between the key-input interface, key_sch and the encryption round controller.

Parameters:
NR_ROUNDS, 10, last round index; the store holds NR_ROUNDS+1 keys.
KEY_W, 128, key and round-key width in bits.

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  reset, asynchronous, active-low.
key_i  in  KEY_W  master key; sampled on key_valid_i & key_ready_o.
key_valid_i  in  1  master key present.
key_ready_o  out  1  ready to accept a master key.
ks_round_nr_o  out  4  round number driven to key_sch.
ks_master_key_o  out  KEY_W  master key driven to key_sch (registered copy).
ks_round_key_i  in  KEY_W  combinational round key returned by key_sch.
rk_req_i  in  1  round-key read request.
rk_idx_i  in  4  requested round index.
rk_valid_o  out  1  read data valid (1-cycle pulse).
rk_o  out  KEY_W  round key read data.
rk_err_o  out  1  rejected read (1-cycle pulse).
keys_ready_o  out  1  all NR_ROUNDS+1 keys are valid.
expand_done_o  out  1  1-cycle pulse when expansion completes.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rnd_q=0, key_q=0, ks_round_nr_o=0, key_ready_o=1 (combinational from state), rk_valid_o=0, rk_o=0, rk_err_o=0, keys_ready_o=0, expand_done_o=0. Store contents are not reset. They cannot be read while keys_ready_o=0.
- States: IDLE, EXPAND, READY. key_ready_o=1 in IDLE and READY, 0 in EXPAND.
- IDLE/READY: on key_valid_i & key_ready_o, set key_q<=key_i and rnd_q<=0, and go to EXPAND. keys_ready_o<=0 on the same edge.
- EXPAND: ks_round_nr_o=rnd_q and ks_master_key_o=key_q. Each cycle, store[rnd_q]<=ks_round_key_i and rnd_q<=rnd_q+1. rnd_q must step by exactly 1 per cycle with no stalls, because key_sch chains its internal register. When rnd_q==NR_ROUNDS, go to READY, set keys_ready_o<=1 and pulse expand_done_o.
- Latency: acceptance edge to keys_ready_o=1 is NR_ROUNDS+1 = 11 cycles.
- ks_round_nr_o=0 outside EXPAND, so key_sch tracks the master key harmlessly.
- Read port: a request is accepted when rk_req_i & keys_ready_o & (rk_idx_i<=NR_ROUNDS). The next cycle gives rk_valid_o=1 and rk_o=store[rk_idx_i]. Registered read, latency 1, back-to-back reads at 1 per cycle.
- A request with keys_ready_o=0 or rk_idx_i>NR_ROUNDS produces rk_err_o=1 the next cycle, rk_valid_o=0, and rk_o holds its previous value.
- Rekey with a simultaneous read in READY: the read is accepted and returns the old key. Entry 0 is first overwritten at the end of the following cycle.
- key_valid_i during EXPAND is ignored (ready=0). The key must be held until accepted.
- Async reset mid-EXPAND returns to IDLE with keys_ready_o=0. A new key must then be loaded.

Decomposition:
- Package aes_pkg holds:
  - NR_ROUNDS and KEY_W constants.
  - key_t as logic[KEY_W-1:0].
  - rnd_idx_t as logic[3:0].
  - key_ctrl_state_e enum {IDLE, EXPAND, READY}.
- Sub-module aes_round_key_store: NR_ROUNDS+1 x KEY_W register file with 1 write port and 1 registered read port. The FSM, counter and handshake logic stay in aes_key_ctrl.
- The bench instantiates the real key_sch against the ks_* ports. key_sch is not instantiated inside this block.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c accepted -> keys_ready_o and expand_done_o after 11 cycles; reading idx 10 returns d014f9a8c9ee2589e13f0cc8b6630ca6 one cycle later, idx 0 returns the master key.
- Back-to-back reads idx 0..10 on consecutive cycles -> 11 consecutive rk_valid_o pulses, each with the FIPS-197 expanded key for that index.
- Read with rk_idx_i=11 in READY, and a read during EXPAND -> rk_err_o pulse, rk_valid_o=0, rk_o unchanged.
- Rekey in READY with key 000102...0f while reading idx 5 in the same cycle -> rk_o returns the old idx-5 key; keys_ready_o drops the next cycle; after 11 cycles idx 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- key_valid_i held high through EXPAND with a changing key_i -> key_ready_o=0 for 11 cycles and the expansion uses the originally accepted key.
- rst_ni asserted at EXPAND cycle 5 -> outputs immediately at reset values, state IDLE, keys_ready_o=0, reads return rk_err_o.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key-schedule control path.
package aes_pkg;

    localparam int NR_ROUNDS = 10;
    localparam int KEY_W     = 128;

    typedef logic [KEY_W-1:0] key_t;
    typedef logic [3:0]       rnd_idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } key_ctrl_state_e;

    localparam rnd_idx_t LAST_RND = rnd_idx_t'(NR_ROUNDS);

endpackage

// File: rtl/aes_round_key_store.sv
// Round-key register file: one write port, one registered read port.
import aes_pkg::*;

module aes_round_key_store (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     we,
    input  rnd_idx_t waddr,
    input  key_t     wdata,
    input  logic     re,
    input  rnd_idx_t raddr,
    output logic     rvalid,
    output key_t     rdata
);

    key_t mem [0:NR_ROUNDS];

    // Storage is deliberately left unreset; the controller gates reads on keys_ready.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= re;
            if (re) begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/aes_key_ctrl.sv
// Sequences key_sch through rounds 0..NR_ROUNDS, captures round keys, serves reads.
// Handshake: a master key transfers on an edge where key_valid_i & key_ready_o are both high.
import aes_pkg::*;

module aes_key_ctrl (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  key_t            key_i,
    input  logic            key_valid_i,
    output logic            key_ready_o,
    output rnd_idx_t        ks_round_nr_o,
    output key_t            ks_master_key_o,
    input  key_t            ks_round_key_i,
    input  logic            rk_req_i,
    input  rnd_idx_t        rk_idx_i,
    output logic            rk_valid_o,
    output key_t            rk_o,
    output logic            rk_err_o,
    output logic            keys_ready_o,
    output logic            expand_done_o,
    output key_ctrl_state_e state_o
);

    key_ctrl_state_e state_q, state_d;
    rnd_idx_t        rnd_q;
    key_t            key_q;
    logic            keys_ready_q;
    logic            expand_done_q;
    logic            rk_err_q;

    logic accept;
    logic expanding;
    logic last_rnd;
    logic rd_ok;

    assign expanding   = (state_q == EXPAND);
    assign key_ready_o = !expanding;
    assign accept      = key_valid_i & key_ready_o;
    assign last_rnd    = expanding && (rnd_q == LAST_RND);
    assign rd_ok       = rk_req_i & keys_ready_q & (rk_idx_i <= LAST_RND);

    // Outside expansion key_sch sees round 0, so it just tracks the master key.
    assign ks_round_nr_o   = expanding ? rnd_q : '0;
    assign ks_master_key_o = key_q;
    assign keys_ready_o    = keys_ready_q;
    assign expand_done_o   = expand_done_q;
    assign rk_err_o        = rk_err_q;
    assign state_o         = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, READY: if (accept) state_d = EXPAND;
            EXPAND:      if (rnd_q == LAST_RND) state_d = READY;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // rnd_q advances every expansion cycle without stalls; key_sch chains on it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rnd_q         <= '0;
            key_q         <= '0;
            keys_ready_q  <= 1'b0;
            expand_done_q <= 1'b0;
            rk_err_q      <= 1'b0;
        end else begin
            if (accept) begin
                key_q <= key_i;
                rnd_q <= '0;
            end else if (expanding) begin
                rnd_q <= last_rnd ? rnd_idx_t'(0) : rnd_q + rnd_idx_t'(1);
            end

            if (accept) begin
                keys_ready_q <= 1'b0;
            end else if (last_rnd) begin
                keys_ready_q <= 1'b1;
            end

            expand_done_q <= last_rnd;
            rk_err_q      <= rk_req_i & !rd_ok;
        end
    end

    aes_round_key_store u_store (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .we     (expanding),
        .waddr  (rnd_q),
        .wdata  (ks_round_key_i),
        .re     (rd_ok),
        .raddr  (rk_idx_i),
        .rvalid (rk_valid_o),
        .rdata  (rk_o)
    );

endmodule

// File: tb/tb_aes_key_ctrl.sv
// Bench for aes_key_ctrl with a behavioural key_sch and a FIPS-197 expansion model.
module tb_aes_key_ctrl;
    import aes_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    key_t            key_i = '0;
    logic            key_valid_i = 1'b0;
    logic            key_ready_o;
    rnd_idx_t        ks_round_nr_o;
    key_t            ks_master_key_o;
    key_t            ks_round_key_i;
    logic            rk_req_i = 1'b0;
    rnd_idx_t        rk_idx_i = '0;
    logic            rk_valid_o;
    key_t            rk_o;
    logic            rk_err_o;
    logic            keys_ready_o;
    logic            expand_done_o;
    key_ctrl_state_e state_o;

    int   tests = 0;
    int   fails = 0;
    int   since = 0;
    key_t exp_keys [0:NR_ROUNDS];
    key_t last_rk = '0;

    always #5 clk_i = ~clk_i;

    aes_key_ctrl dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .key_i           (key_i),
        .key_valid_i     (key_valid_i),
        .key_ready_o     (key_ready_o),
        .ks_round_nr_o   (ks_round_nr_o),
        .ks_master_key_o (ks_master_key_o),
        .ks_round_key_i  (ks_round_key_i),
        .rk_req_i        (rk_req_i),
        .rk_idx_i        (rk_idx_i),
        .rk_valid_o      (rk_valid_o),
        .rk_o            (rk_o),
        .rk_err_o        (rk_err_o),
        .keys_ready_o    (keys_ready_o),
        .expand_done_o   (expand_done_o),
        .state_o         (state_o)
    );

    // ---------------- AES arithmetic ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        logic [7:0] s;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input int r);
        logic [7:0] c = 8'h01;
        for (int i = 1; i < r; i++) c = xtime(c);
        return c;
    endfunction

    // ---------------- behavioural key_sch (chained round register) ----------------
    function automatic key_t ks_next(input key_t k, input int r);
        logic [31:0] t, n0, n1, n2, n3;
        t  = subword({k[23:0], k[31:24]}) ^ {rcon(r), 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    key_t ks_prev_q;
    always_ff @(posedge clk_i) ks_prev_q <= ks_round_key_i;
    always_comb begin
        ks_round_key_i = ks_master_key_o;
        if (ks_round_nr_o != 0) ks_round_key_i = ks_next(ks_prev_q, int'(ks_round_nr_o));
    end

    // ---------------- reference: word-wise FIPS-197 expansion ----------------
    task automatic model_expand(input key_t k);
        logic [31:0] w [0:4*NR_ROUNDS+3];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 4*(NR_ROUNDS+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = subword({t[23:0], t[31:24]}) ^ {rcon(i/4), 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR_ROUNDS; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- check and drivers ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        since++;
    endtask

    task automatic start_key(input key_t k, input bit keep_valid);
        key_i = k;
        key_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        since = 0;
        if (!keep_valid) key_valid_i = 1'b0;
        check("ready_low_after_accept", key_ready_o, 0);
        check("state_expand", state_o, EXPAND);
    endtask

    task automatic wait_ready(input bit churn);
        while (!keys_ready_o && since < 40) begin
            if (churn) key_i = {$urandom, $urandom, $urandom, $urandom};
            step();
            if (since <= NR_ROUNDS) begin
                check("key_ready_in_expand", key_ready_o, 0);
                check("ks_round_nr", ks_round_nr_o, since);
            end
        end
        key_valid_i = 1'b0;
        check("expand_latency", since, NR_ROUNDS + 1);
        check("expand_done", expand_done_o, 1);
        check("key_ready_in_ready", key_ready_o, 1);
        check("ks_round_nr_idle", ks_round_nr_o, 0);
        step();
        check("expand_done_pulse", expand_done_o, 0);
    endtask

    task automatic read_chk(input int idx, input key_t exp, input string tag);
        rk_req_i = 1'b1;
        rk_idx_i = rnd_idx_t'(idx);
        step();
        rk_req_i = 1'b0;
        check({tag, "_valid"}, rk_valid_o, 1);
        check({tag, "_err"}, rk_err_o, 0);
        check(tag, rk_o, exp);
        last_rk = exp;
    endtask

    task automatic read_err(input int idx, input string tag);
        rk_req_i = 1'b1;
        rk_idx_i = rnd_idx_t'(idx);
        step();
        rk_req_i = 1'b0;
        check({tag, "_err"}, rk_err_o, 1);
        check({tag, "_valid"}, rk_valid_o, 0);
        check({tag, "_hold"}, rk_o, last_rk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, state_o, IDLE);
        check({tag, "_key_ready"}, key_ready_o, 1);
        check({tag, "_keys_ready"}, keys_ready_o, 0);
        check({tag, "_ks_round_nr"}, ks_round_nr_o, 0);
        check({tag, "_rk_valid"}, rk_valid_o, 0);
        check({tag, "_rk_o"}, rk_o, 0);
        check({tag, "_rk_err"}, rk_err_o, 0);
        check({tag, "_expand_done"}, expand_done_o, 0);
    endtask

    initial begin
        key_t fips_key, new_key, k, old5;
        fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        new_key  = 128'h000102030405060708090a0b0c0d0e0f;

        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        check("reset_master_key", ks_master_key_o, 0);
        rst_ni = 1'b1;
        step();
        check_reset_outputs("post_reset");

        // FIPS-197 vector
        model_expand(fips_key);
        start_key(fips_key, 1'b0);
        wait_ready(1'b0);
        check("keys_ready", keys_ready_o, 1);
        read_chk(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_rk10");
        read_chk(0, fips_key, "fips_rk0");

        // back-to-back reads 0..10
        for (int i = 0; i <= NR_ROUNDS; i++) begin
            rk_req_i = 1'b1;
            rk_idx_i = rnd_idx_t'(i);
            step();
            check("b2b_valid", rk_valid_o, 1);
            check("b2b_data", rk_o, exp_keys[i]);
        end
        rk_req_i = 1'b0;
        last_rk = exp_keys[NR_ROUNDS];
        step();
        check("b2b_valid_end", rk_valid_o, 0);

        // out-of-range reads
        read_err(11, "idx11");
        read_err(15, "idx15");
        step();
        check("err_pulse_end", rk_err_o, 0);

        // rekey with a simultaneous read of idx 5
        old5 = exp_keys[5];
        rk_req_i = 1'b1;
        rk_idx_i = 4'd5;
        start_key(new_key, 1'b0);
        rk_req_i = 1'b0;
        check("rekey_read_valid", rk_valid_o, 1);
        check("rekey_read_old", rk_o, old5);
        check("rekey_keys_ready_drop", keys_ready_o, 0);
        last_rk = old5;
        model_expand(new_key);
        read_err($urandom_range(0, NR_ROUNDS), "read_in_expand");
        wait_ready(1'b0);
        read_chk(10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "rekey_rk10");
        read_chk(0, new_key, "rekey_rk0");

        // key_i churning while valid is held through expansion
        k = {$urandom, $urandom, $urandom, $urandom};
        model_expand(k);
        start_key(k, 1'b1);
        wait_ready(1'b1);
        for (int i = 0; i <= NR_ROUNDS; i++) begin
            int idx = $urandom_range(0, NR_ROUNDS);
            read_chk(idx, exp_keys[idx], "churn_rand_read");
        end

        // random keys, full readback
        for (int n = 0; n < 2; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            model_expand(k);
            start_key(k, 1'b0);
            wait_ready(1'b0);
            for (int i = 0; i <= NR_ROUNDS; i++) read_chk(i, exp_keys[i], "rand_key_read");
        end

        // asynchronous reset at expansion cycle 5
        k = {$urandom, $urandom, $urandom, $urandom};
        start_key(k, 1'b0);
        repeat (5) step();
        #2 rst_ni = 1'b0;
        #1;
        check_reset_outputs("mid_expand_reset");
        last_rk = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        read_err(3, "read_after_reset");
        model_expand(fips_key);
        start_key(fips_key, 1'b0);
        wait_ready(1'b0);
        read_chk(10, exp_keys[10], "reload_rk10");
        read_chk(4, exp_keys[4], "reload_rk4");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
